// File: rtl/pong_pkg.sv
// Shared state encoding for the down_timer countdown FSM.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with start/pause control and a one-cycle done pulse.
// Optional build macro DOWN_TIMER_AUTORELOAD_EN: reload and keep running at terminal count.
module down_timer
   import pong_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             dec,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             done_nxt;
`ifdef DOWN_TIMER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload, reload_nxt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         out   <= '0;
         done  <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
         reload <= '0;
`endif
      end else begin
         state <= state_nxt;
         out   <= count_nxt;
         done  <= done_nxt;
`ifdef DOWN_TIMER_AUTORELOAD_EN
         reload <= reload_nxt;
`endif
      end
   end

   // Priority chain: load, then start, then pause, then dec.
   always_comb begin
      state_nxt = state;
      count_nxt = out;
      done_nxt  = 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_nxt = reload;
`endif
      if (load) begin
         state_nxt = IDLE;
         count_nxt = load_val;
`ifdef DOWN_TIMER_AUTORELOAD_EN
         reload_nxt = load_val;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start && out != '0)
                  state_nxt = RUN;
            end
            PAUSED: begin
               if (start)
                  state_nxt = RUN;
            end
            RUN: begin
               // start is a no-op while running, so pause gets its turn.
               if (pause) begin
                  state_nxt = PAUSED;
               end else if (dec) begin
                  if (out == ONE) begin
                     done_nxt = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                     count_nxt = reload;
`else
                     count_nxt = '0;
                     state_nxt = IDLE;
`endif
                  end else begin
                     count_nxt = out - ONE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy = (state == RUN) || (state == PAUSED);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized traffic against a reference model.
module tb_down_timer;

   localparam int WIDTH = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             pause;
   logic             dec;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;

   down_timer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .dec      (dec),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: remaining count, reload value, mode name, and done flag.
   int    m_cnt;
   int    m_rel;
   string m_mode;
   bit    m_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out"},  32'(out),  32'(m_cnt));
      check({tag, ".busy"}, 32'(busy), 32'(m_mode != "IDLE"));
      check({tag, ".done"}, 32'(done), 32'(m_done));
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_rel  = 0;
      m_mode = "IDLE";
      m_done = 1'b0;
   endtask

   // One clock of behaviour as described by the requirement text.
   task automatic model_step(input bit ld, input int lv, input bit st, input bit pa, input bit de);
      m_done = 1'b0;
      if (ld) begin
         m_cnt  = lv;
         m_rel  = lv;
         m_mode = "IDLE";
      end else if (st && m_mode == "IDLE" && m_cnt != 0) begin
         m_mode = "RUN";
      end else if (st && m_mode == "PAUSED") begin
         m_mode = "RUN";
      end else if (pa && m_mode == "RUN") begin
         m_mode = "PAUSED";
      end else if (de && m_mode == "RUN") begin
         if (m_cnt == 1) begin
            m_done = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            m_cnt = m_rel;
`else
            m_cnt  = 0;
            m_mode = "IDLE";
`endif
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
   endtask

   // Called at a falling edge: drive, clock once, compare at the next falling edge.
   task automatic step(input string tag, input bit ld, input int lv, input bit st,
                       input bit pa, input bit de);
      load     = ld;
      load_val = WIDTH'(lv);
      start    = st;
      pause    = pa;
      dec      = de;
      @(posedge clk);
      model_step(ld, lv, st, pa, de);
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      reset    = 1'b0;
      load     = 1'b0;
      load_val = '0;
      start    = 1'b0;
      pause    = 1'b0;
      dec      = 1'b0;
      model_reset();

      #1;
      check("reset.out",  32'(out),  32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Basic countdown 3,2,1,0 with dec held high.
      step("cd.load",  1, 3, 0, 0, 0);
      step("cd.start", 0, 0, 1, 0, 1);
      check("cd.start_out", 32'(out), 32'd3);
      for (int i = 0; i < 4; i++) step("cd.dec", 0, 0, 0, 0, 1);

      // Pause holds the count even with dec high, then resume.
      step("pz.load",  1, 5, 0, 0, 0);
      step("pz.start", 0, 0, 1, 0, 0);
      step("pz.dec1",  0, 0, 0, 0, 1);
      step("pz.dec2",  0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step("pz.hold", 0, 0, 0, 1, 1);
      check("pz.held_out",  32'(out),  32'd3);
      check("pz.held_busy", 32'(busy), 32'd1);
      step("pz.resume", 0, 0, 1, 0, 1);
      check("pz.resume_out", 32'(out), 32'd3);
      step("pz.run", 0, 0, 0, 0, 1);
      check("pz.run_out", 32'(out), 32'd2);

      // Load wins over start in the same cycle.
      step("ls.both", 1, 7, 1, 0, 1);
      check("ls.out",  32'(out),  32'd7);
      check("ls.busy", 32'(busy), 32'd0);
      step("ls.start", 0, 0, 1, 0, 0);
      check("ls.run_busy", 32'(busy), 32'd1);

      // Zero load: start has no effect.
      step("z.load", 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("z.start", 0, 0, 1, 0, 1);
      check("z.busy", 32'(busy), 32'd0);
      check("z.out",  32'(out),  32'd0);

      // Asynchronous reset between edges while running at 4.
      step("ar.load",  1, 6, 0, 0, 0);
      step("ar.start", 0, 0, 1, 0, 0);
      step("ar.dec1",  0, 0, 0, 0, 1);
      step("ar.dec2",  0, 0, 0, 0, 1);
      check("ar.pre_out", 32'(out), 32'd4);
      dec = 1'b0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("ar.out",  32'(out),  32'd0);
      check("ar.busy", 32'(busy), 32'd0);
      check("ar.done", 32'(done), 32'd0);
      load     = 1'b1;
      load_val = WIDTH'(9);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_model("ar.held");
      reset = 1'b1;
      step("ar.after", 0, 0, 0, 0, 1);

`ifdef DOWN_TIMER_AUTORELOAD_EN
      // Auto-reload: 2,1,2,1,... with done on every reload.
      step("rl.load",  1, 2, 0, 0, 0);
      step("rl.start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) step("rl.dec", 0, 0, 0, 0, 1);
      check("rl.busy", 32'(busy), 32'd1);
`endif

      // Randomized traffic with small load values so terminal counts are frequent.
      for (int i = 0; i < 400; i++) begin
         bit ld, st, pa, de;
         int lv;
         ld = ($urandom_range(0, 99) < 6);
         st = ($urandom_range(0, 99) < 15);
         pa = ($urandom_range(0, 99) < 10);
         de = ($urandom_range(0, 99) < 75);
         lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << WIDTH) - 1))
                                          : int'($urandom_range(0, 6));
         step("rnd", ld, lv, st, pa, de);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, counter and load width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-004 SHALL have port load, input, 1, load strobe; captures load_val.
REQ-005 SHALL have port load_val, input, WIDTH, start value for the countdown.
REQ-006 SHALL have port start, input, 1, start or resume the countdown.
REQ-007 SHALL have port pause, input, 1, freeze the countdown while running.
REQ-008 SHALL have port dec, input, 1, decrement enable (tick) while running.
REQ-009 SHALL have port out, output, WIDTH, current remaining count (registered).
REQ-010 SHALL have port busy, output, 1, high in RUN or PAUSED.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on terminal count.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSED, plus an internal reload register of WIDTH bits.
REQ-013 SHALL apply per-cycle priority: load > start > pause > dec.
REQ-014 SHALL, on load in any state: out <= load_val, reload <= load_val, state -> IDLE, done = 0.
REQ-015 SHALL, on start in IDLE with out != 0, go to RUN; start in IDLE with out == 0 SHALL have no effect.
REQ-016 SHALL, on start in PAUSED, go to RUN with out unchanged; start in RUN SHALL have no effect, so pause is evaluated.
REQ-017 SHALL, on pause in RUN, go to PAUSED with no decrement that cycle; pause in IDLE or PAUSED SHALL have no effect.
REQ-018 SHALL, in RUN with dec = 1 and out > 1, set out <= out - 1.
REQ-019 SHALL, in RUN with dec = 1 and out == 1, set out <= 0, drive done = 1 in the same cycle out first reads 0, and go to IDLE.
REQ-020 SHALL ignore dec in IDLE and PAUSED; out SHALL never wrap below 0.
REQ-021 SHALL drive done from a register, high for exactly one cycle per terminal count, and low otherwise.
REQ-022 SHALL derive busy combinationally from state (RUN or PAUSED).

Reset
REQ-023 SHALL, while reset = 0, immediately force out = 0, reload = 0, state = IDLE, done = 0, busy = 0, independent of clk.
REQ-024 SHALL ignore all inputs during reset; operation resumes on the first rising clk edge after reset returns to 1.
REQ-025 SHALL, on reset mid-countdown, discard the count; no done pulse is generated.

Configuration
REQ-026 SHALL honour macro DOWN_TIMER_AUTORELOAD_EN.
REQ-027 SHALL, with DOWN_TIMER_AUTORELOAD_EN defined, at terminal count (RUN, dec, out == 1) set out <= reload, pulse done, and remain in RUN.
REQ-028 SHALL, without DOWN_TIMER_AUTORELOAD_EN, behave per REQ-019; the reload register MAY be removed.

Structure
REQ-029 SHALL take the state encoding typedef (IDLE = 0, RUN = 1, PAUSED = 2, 2 bits) from shared package pong_pkg.
REQ-030 SHALL be a single module with no sub-module; the decrement datapath is inline.

Verification
REQ-031 SHALL cover: WIDTH = 10, load_val = 3, start, dec held high -> out 3, 2, 1, 0 on successive cycles; done high only on the cycle out = 0; busy falls the same cycle.
REQ-032 SHALL cover: load_val = 5, start, two dec ticks, then pause with dec = 1 for 4 cycles -> out holds 3, busy = 1; start -> countdown resumes from 3.
REQ-033 SHALL cover: load and start in the same cycle with load_val = 7 -> out = 7, state IDLE, busy = 0; a later start enters RUN.
REQ-034 SHALL cover: load_val = 0, start -> remains IDLE, out = 0, done never asserted.
REQ-035 SHALL cover: reset driven low asynchronously between clk edges while in RUN with out = 4 -> out = 0, busy = 0 before the next edge; no done pulse.
REQ-036 SHALL cover: with DOWN_TIMER_AUTORELOAD_EN, load_val = 2, start, dec high -> out 2, 1, 2, 1, 2, ...; done pulses each cycle the reload occurs; busy stays 1.
